// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared types and constants for the instruction memory loader
//
// Purpose: loader FSM state encoding, stream framing sizes, and the RAM
// capacity helper used to reject oversize word counts.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_W_HI,
    S_W_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } ldr_state_e;

  // Stream framing: big-endian word count up front, one XOR byte at the end.
  localparam int COUNT_BYTES = 2;
  localparam int CKSUM_BYTES = 1;

  // Number of instruction words the RAM can hold.
  function automatic int unsigned max_words(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/ldr_checksum.sv
// rtl/ldr_checksum.sv - 8-bit running XOR over the instruction bytes of a load
//
// Purpose: accumulates the XOR of every enabled byte; clear restarts it at 0.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous, active-high reset
//   clear_i  restart the sum at zero (wins over en_i)
//   en_i     fold byte_i into the sum this cycle
//   byte_i   stream byte
//   sum_o    current XOR of all bytes folded in since the last clear
module ldr_checksum (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream program loader for the writable instruction RAM
//
// Purpose: accepts a framed byte stream (count, words high byte first, XOR
// checksum), writes each word at its even byte address and stalls the CPU
// while loading or after a failed load.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle pulse, begins a load from IDLE or ERR
//   in_valid   in_data holds a byte
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (decoded from state)
//   wr_en      instruction RAM write strobe
//   wr_addr    byte address of the word, always even
//   wr_data    instruction word
//   busy       load in progress
//   done       one-cycle pulse after a successful load
//   err        failure flag, held until the next load starts or reset
//   cpu_stall  hold the processor PC
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int INST_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [INST_WIDTH-1:0] wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_stall
);

  ldr_state_e state_q, state_d;

  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [7:0]            hi_q, hi_d;
  logic [DEPTH_LOG2:0]   n_q, n_d;
  logic [DEPTH_LOG2:0]   idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [INST_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [INST_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  stall_q, stall_d;

  logic [15:0] count_full;
  logic        cs_clear;
  logic        cs_en;
  logic [7:0]  cs_sum;

  assign count_full = {cnt_hi_q, in_data};

  ldr_checksum u_checksum (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (cs_clear),
    .en_i    (cs_en),
    .byte_i  (in_data),
    .sum_o   (cs_sum)
  );

  // Next-state, datapath updates and in_ready decode. In every byte-taking
  // state in_ready is 1, so in_valid alone marks an accepted byte there.
  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    hi_d      = hi_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cs_clear  = 1'b0;
    cs_en     = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d  = S_CNT_HI;
          idx_d    = '0;
          cs_clear = 1'b1;
        end
      end
      S_CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_hi_d = in_data;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (32'(count_full) > max_words(DEPTH_LOG2)) begin
            state_d = S_ERR;
          end else if (count_full == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            n_d     = count_full[DEPTH_LOG2:0];
            state_d = S_W_HI;
          end
        end
      end
      S_W_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_d    = in_data;
          cs_en   = 1'b1;
          state_d = S_W_LO;
        end
      end
      S_W_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = INST_WIDTH'(idx_q) << 1;
          wr_data_d = INST_WIDTH'({hi_q, in_data});
          idx_d     = idx_q + 1'b1;
          cs_en     = 1'b1;
          // idx_d now counts words written; equal to N means that was the last.
          state_d   = (idx_d == n_q) ? S_CHECK : S_W_HI;
        end
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == cs_sum) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they track the
  // state register exactly, with no decode glitches at the ports.
  always_comb begin
    busy_d  = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
              (state_d == S_W_HI)   || (state_d == S_W_LO)   ||
              (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    stall_d = busy_d || err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_hi_q  <= 8'h00;
      hi_q      <= 8'h00;
      n_q       <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      hi_q      <= hi_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_stall = stall_q;

endmodule
